// File: rtl/riscv_test_monitor_if.sv
// Monitor bus: core observation inputs (retire, write-back, store) and verdict outputs.
interface riscv_test_monitor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) ();
  logic             start;
  logic             ret_valid;
  logic [XLEN-1:0]  ret_pc;
  logic             wb_en;
  logic [4:0]       wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic             st_valid;
  logic [XLEN-1:0]  st_addr;
  logic [XLEN-1:0]  st_data;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [XLEN-1:0]  fail_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    output start, ret_valid, ret_pc, wb_en, wb_addr, wb_data, st_valid, st_addr, st_data,
    input  done, pass, fail, timeout, fail_code, cycle_cnt, instret_cnt
  );

  modport slave (
    input  start, ret_valid, ret_pc, wb_en, wb_addr, wb_data, st_valid, st_addr, st_data,
    output done, pass, fail, timeout, fail_code, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/riscv_test_monitor.sv
// riscv-tests completion monitor: end-PC or tohost detection, sticky verdict, cycle/instret counters.
// Optional macro RISCV_TEST_MONITOR_HANG_DETECT_EN adds same-PC self-loop detection.
module riscv_test_monitor #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     MODE        = 0,
  parameter logic [XLEN-1:0] END_PC      = 32'h44,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000,
  parameter int unsigned     GP_IDX      = 3,
  parameter int unsigned     TIMEOUT     = 6000,
  parameter int unsigned     CNT_W       = 32
) (
  input logic clk,
  input logic rst,
  riscv_test_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       LP_GP      = 5'(GP_IDX);
  localparam logic             LP_TO_EN   = (TIMEOUT != 0);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cycle, r_instret;
  logic [XLEN-1:0]  r_gp, r_fail_code, w_fail_code_d;
  logic             r_pass, r_fail, r_tout, r_done;
  logic             w_pass_d, w_fail_d, w_tout_d, w_done_d;
  logic             w_gp_wr, w_enter_run, w_to_hit, w_hang_hit;
  logic             w_end_hit, w_end_pass;
  logic [XLEN-1:0]  w_gp_eff, w_end_code;

  // gp as seen this cycle, including a same-cycle write-back
  assign w_gp_wr  = bus.wb_en && (bus.wb_addr == LP_GP);
  assign w_gp_eff = w_gp_wr ? bus.wb_data : r_gp;
  assign w_to_hit = LP_TO_EN && (r_cycle == LP_TO_LAST);

  // End-of-test event and its result, selected by MODE
  always_comb begin
    w_end_hit  = 1'b0;
    w_end_pass = 1'b0;
    w_end_code = '0;
    if (MODE == 0) begin
      w_end_hit  = bus.ret_valid && (bus.ret_pc == END_PC);
      w_end_pass = (w_gp_eff == XLEN'(1));
      w_end_code = w_gp_eff >> 1;
    end else begin
      w_end_hit  = bus.st_valid && (bus.st_addr == TOHOST_ADDR) && bus.st_data[0];
      w_end_pass = (bus.st_data == XLEN'(1));
      w_end_code = bus.st_data >> 1;
    end
  end

`ifdef RISCV_TEST_MONITOR_HANG_DETECT_EN
  logic [15:0]     r_hang_cnt, w_hang_nx;
  logic [XLEN-1:0] r_last_pc;
  logic            w_hang_ret;

  // The END_PC retire in MODE 0 is the end event, not loop evidence
  assign w_hang_ret = bus.ret_valid && !((MODE == 0) && (bus.ret_pc == END_PC));

  always_comb begin
    w_hang_nx = r_hang_cnt;
    if (w_hang_ret) begin
      w_hang_nx = ((r_hang_cnt != 16'd0) && (bus.ret_pc == r_last_pc)) ?
                  (r_hang_cnt + 16'd1) : 16'd1;
    end
  end

  assign w_hang_hit = w_hang_ret && (w_hang_nx == 16'd1024);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hang_cnt <= '0;
      r_last_pc  <= '0;
    end else if (w_enter_run) begin
      r_hang_cnt <= '0;
      r_last_pc  <= '0;
    end else if ((r_state == S_RUN) && w_hang_ret) begin
      r_hang_cnt <= w_hang_nx;
      r_last_pc  <= bus.ret_pc;
    end
  end
`else
  assign w_hang_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // Next state: end event beats hang, hang beats timeout
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nx = S_RUN;
      S_RUN: begin
        if (w_end_hit)       w_state_nx = w_end_pass ? S_PASS : S_FAIL;
        else if (w_hang_hit) w_state_nx = S_FAIL;
        else if (w_to_hit)   w_state_nx = S_TOUT;
      end
      S_PASS, S_FAIL, S_TOUT: if (bus.start) w_state_nx = S_RUN;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_enter_run = (w_state_nx == S_RUN) && (r_state != S_RUN);

  // Output decode of the next state, registered below
  always_comb begin
    w_pass_d      = (w_state_nx == S_PASS);
    w_tout_d      = (w_state_nx == S_TOUT);
    w_fail_d      = (w_state_nx == S_FAIL) || w_tout_d;
    w_done_d      = w_pass_d || w_fail_d;
    w_fail_code_d = r_fail_code;
    if (w_enter_run) begin
      w_fail_code_d = '0;
    end else if (r_state == S_RUN) begin
      if (w_state_nx == S_FAIL)      w_fail_code_d = w_end_hit ? w_end_code : '1;
      else if (w_state_nx == S_TOUT) w_fail_code_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_tout      <= 1'b0;
      r_done      <= 1'b0;
      r_fail_code <= '0;
    end else begin
      r_pass      <= w_pass_d;
      r_fail      <= w_fail_d;
      r_tout      <= w_tout_d;
      r_done      <= w_done_d;
      r_fail_code <= w_fail_code_d;
    end
  end

  // Saturating counters and gp shadow, live only in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
      r_gp      <= '0;
    end else if (w_enter_run) begin
      r_cycle   <= '0;
      r_instret <= '0;
      r_gp      <= '0;
    end else if (r_state == S_RUN) begin
      if (r_cycle != '1)                      r_cycle   <= r_cycle + CNT_W'(1);
      if (bus.ret_valid && (r_instret != '1)) r_instret <= r_instret + CNT_W'(1);
      if (w_gp_wr)                            r_gp      <= bus.wb_data;
    end
  end

  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;
  assign bus.timeout     = r_tout;
  assign bus.fail_code   = r_fail_code;
  assign bus.cycle_cnt   = r_cycle;
  assign bus.instret_cnt = r_instret;

endmodule
